// File: rtl/softmax_sched_pkg.sv
// Shared types and width helpers for the softmax engine scheduler.
package softmax_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

  function automatic int id_w(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic int mat_w(input int data_width, input int l, input int n);
    return data_width * l * n * l;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter
  import softmax_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/softmax_sched.sv
// Round-robin scheduler sharing one softmax_approx engine among NUM_REQ requesters.
// Optional watchdog abort in S_WAIT enabled by `define SOFTMAX_SCHED_TIMEOUT_EN.
module softmax_sched
  import softmax_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int L              = 8,
  parameter int N              = 1,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int MAT_W = mat_w(DATA_WIDTH, L, N),
  localparam int ID_W  = id_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MAT_W-1:0] req_data,
  output logic                     eng_start,
  output logic [MAT_W-1:0]         eng_a_in,
  input  logic                     eng_done,
  input  logic [MAT_W-1:0]         eng_a_out,
  output logic                     eng_flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [MAT_W-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy
);

  sched_state_t       state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic [MAT_W-1:0]   a_lat;
  logic [MAT_W-1:0]   r_lat;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               any_req;
  logic               expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign req_ready  = (state == S_IDLE) ? gnt : '0;
  assign eng_start  = (state == S_START);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign eng_a_in   = a_lat;
  assign resp_data  = r_lat;
  assign resp_id    = cur_id;

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wdog;
  logic             err_q;

  // A done arriving on the limit cycle takes priority over the abort.
  assign expired   = (state == S_WAIT) && !eng_done && (wdog == CNT_W'(TIMEOUT_CYCLES));
  assign eng_flush = expired;
  assign resp_err  = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_START) begin
        wdog <= '0;
      end else if (state == S_WAIT && !expired) begin
        wdog <= wdog + CNT_W'(1);
      end
      if (state == S_WAIT) begin
        if (eng_done) begin
          err_q <= 1'b0;
        end else if (expired) begin
          err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign expired   = 1'b0;
  assign eng_flush = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      a_lat  <= '0;
      r_lat  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            a_lat  <= req_data[gnt_idx*MAT_W +: MAT_W];
            cur_id <= gnt_idx;
            state  <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (eng_done) begin
            r_lat <= eng_a_out;
            state <= S_RESP;
          end else if (expired) begin
            r_lat <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          // Pointer moves only on completion so a granted requester keeps its slot.
          if (resp_ready) begin
            rr_ptr <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_sched.sv
// Randomized self-checking bench for softmax_sched with a fixed-latency engine stub.
module tb_softmax_sched;
  import softmax_sched_pkg::*;

  localparam int DW = 16;
  localparam int LL = 8;
  localparam int NN = 1;
  localparam int NR = 4;
  localparam int TO = 8;
  localparam int MW = DW * LL * NN * LL;
  localparam int IW = 2;
  localparam logic [MW-1:0] MASK = {(MW/16){16'h00FF}};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*MW-1:0] req_data;
  logic            eng_start, eng_done, eng_flush;
  logic [MW-1:0]   eng_a_in, eng_a_out, resp_data;
  logic            resp_valid, resp_ready, resp_err, busy;
  logic [IW-1:0]   resp_id;

  always #5 clk = ~clk;

  softmax_sched #(
    .DATA_WIDTH(DW), .L(LL), .N(NN), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .eng_start(eng_start), .eng_a_in(eng_a_in),
    .eng_done(eng_done), .eng_a_out(eng_a_out), .eng_flush(eng_flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  logic [MW-1:0] mdata [NR];
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*MW +: MW] = mdata[i];
  end

  // Engine stub: done exactly stub_lat cycles after start, result = input ^ 00FF per element.
  int            stub_lat = 20;
  bit            stub_never = 1'b0;
  bit            spur_done = 1'b0;
  int            scnt;
  bit            sact;
  logic [MW-1:0] scap;

  always @(posedge clk) begin
    if (!rst_n || eng_flush) begin
      sact <= 1'b0;
      scnt <= 0;
    end else if (eng_start) begin
      sact <= 1'b1;
      scnt <= 1;
      scap <= eng_a_in;
    end else if (sact) begin
      if (scnt == stub_lat) sact <= 1'b0;
      else scnt <= scnt + 1;
    end
  end
  assign eng_done  = (sact && !stub_never && scnt == stub_lat) || spur_done;
  assign eng_a_out = scap ^ MASK;

  int            checks = 0;
  int            failures = 0;
  int            mptr = 0;
  logic [NR-1:0] pending = '0;
  logic [MW-1:0] last_resp = '0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_mat(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    check({tag, "_lo"}, act[511:0], exp[511:0]);
    check({tag, "_hi"}, act[1023:512], exp[1023:512]);
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < MW/32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, eng_start, 0);
    check({tag, "_flush"}, eng_flush, 0);
    check({tag, "_rvalid"}, resp_valid, 0);
    check({tag, "_rerr"}, resp_err, 0);
    check({tag, "_rid"}, resp_id, 0);
    check({tag, "_rready"}, req_ready, 0);
    check_mat({tag, "_rdata"}, resp_data, '0);
    check_mat({tag, "_ain"}, eng_a_in, '0);
  endtask

  // One full job from grant to response acceptance; called with the DUT idle.
  task automatic do_txn(input bit keep, input int bp, input bit spur, output int gout);
    int g, lat;
    logic [MW-1:0] exp_d;
    req_valid = pending;
    #1;
    g = pick(pending, mptr);
    gout = g;
    check("grant", req_ready, 4'b0001 << g);
    check("busy_idle", busy, 0);
    tick();
    if (!keep) begin
      pending[g] = 1'b0;
      req_valid = pending;
    end
    #1;
    check("start", eng_start, 1);
    check("ready_in_start", req_ready, 0);
    check_mat("a_in", eng_a_in, mdata[g]);
    exp_d = mdata[g] ^ MASK;
    lat = 0;
    while (lat < 60) begin
      tick();
      lat++;
      resp_ready = 1'($urandom);
      #1;
      if (lat == 1) check("start_pulse", eng_start, 0);
      if (resp_valid) break;
    end
    resp_ready = 1'b0;
    check("latency", lat, stub_lat + 1);
    check("no_flush", eng_flush, 0);
    for (int c = 0; c < bp; c++) begin
      spur_done = spur && (c == 0);
      tick();
      spur_done = 1'b0;
      #1;
      check("bp_valid", resp_valid, 1);
      check("bp_id", resp_id, g);
      check("bp_ready", req_ready, 0);
      check_mat("bp_data", resp_data, exp_d);
    end
    resp_ready = 1'b1;
    #1;
    check("resp_valid", resp_valid, 1);
    check("resp_id", resp_id, g);
    check("resp_err", resp_err, 0);
    check_mat("resp_data", resp_data, exp_d);
    last_resp = exp_d;
    tick();
    resp_ready = 1'b0;
    mptr = (g + 1) % NR;
    #1;
    check("idle_after", busy, 0);
  endtask

  initial begin
    int g, seen, lat;
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NR; i++) mdata[i] = '0;
`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    stub_lat = 6;
`endif
    repeat (3) tick();
    reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // All requesters held: service order 0,1,2,3,0.
    for (int i = 0; i < NR; i++) mdata[i] = rand_mat();
    pending = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_txn(1'b1, k % 3, 1'b0, g);
      check("rr_order", g, k % NR);
    end
    pending = '0;
    req_valid = '0;

    // Spurious done in idle.
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    #1;
    check("spur_idle_busy", busy, 0);
    check("spur_idle_valid", resp_valid, 0);
    check_mat("spur_idle_data", resp_data, last_resp);

    // Single request with known data, backpressure and spurious done in S_RESP.
    mdata[2] = {(MW/16){16'h0100}};
    pending = 4'b0100;
    do_txn(1'b0, 10, 1'b1, g);
    check_mat("single_01ff", last_resp, {(MW/16){16'h01FF}});

    // Reset mid-S_WAIT at stub cycle 10.
    mdata[1] = rand_mat();
    pending = 4'b0010;
    req_valid = pending;
    #1;
    check("rst_grant", req_ready, 4'b0010 << 0);
    tick();
    pending = '0;
    req_valid = '0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    reset_vals("midwait");
    mptr = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (resp_valid) seen = 1;
    end
    check("no_resp_after_rst", seen, 0);
    for (int i = 0; i < NR; i++) mdata[i] = rand_mat();
    pending = 4'b1111;
    do_txn(1'b0, 1, 1'b0, g);
    check("ptr_after_rst", g, 0);

`ifdef SOFTMAX_SCHED_TIMEOUT_EN
    // Engine never finishes: abort after TO cycles in S_WAIT.
    stub_never = 1'b1;
    req_valid = pending;
    #1;
    g = pick(pending, mptr);
    check("to_grant", req_ready, 4'b0001 << g);
    tick();
    pending[g] = 1'b0;
    req_valid = pending;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (eng_flush) break;
    end
    check("to_flush_lat", lat, TO + 1);
    tick();
    check("to_flush_pulse", eng_flush, 0);
    check("to_valid", resp_valid, 1);
    check("to_err", resp_err, 1);
    check("to_id", resp_id, g);
    check_mat("to_data", resp_data, '0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mptr = (g + 1) % NR;
    stub_never = 1'b0;
    // Done on the limit cycle still yields a normal response.
    stub_lat = TO + 1;
    if (pending == '0) begin
      pending[0] = 1'b1;
      mdata[0] = rand_mat();
    end
    do_txn(1'b0, 0, 1'b0, g);
    stub_lat = 6;
`endif

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && ($urandom % 2 == 0)) begin
          pending[i] = 1'b1;
          mdata[i] = rand_mat();
        end
      end
      if (pending == '0) begin
        g = $urandom_range(0, NR - 1);
        pending[g] = 1'b1;
        mdata[g] = rand_mat();
      end
      do_txn(1'b0, $urandom_range(0, 4), 1'($urandom), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
